// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ ADC readout block.
package daq_pkg;

  // Readout sequencer states; explicit encodings keep debug dumps stable.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_BUSY_HI = 3'd1,
    WAIT_BUSY_LO = 3'd2,
    RD_LOW       = 3'd3,
    RD_HIGH      = 3'd4,
    OUT_WAIT     = 3'd5
  } daq_state_e;

  // Logic levels used when comparing the synchronised busy line.
  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  // Largest of three cycle counts; sizes the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/daq_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module daq_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first one a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/daq_adc_readout.sv
// Conversion-triggered ADC parallel-bus reader.
// Waits for the ADC busy pulse after each conversion start, then strobes
// out NUM_CHANNELS words with CS_n/RD_n and presents each on a stream.
// Stream handshake: a beat transfers on any rising clk edge where
// valid_o && ready_i; once valid_o is high, sample_o/chan_o/last_o hold
// steady and valid_o stays high until that transfer (only en_i low or
// reset may drop it early).
module daq_adc_readout
  import daq_pkg::*;
#(
  parameter int NUM_CHANNELS   = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int RD_LOW_CYCLES  = 3,
  parameter int RD_HIGH_CYCLES = 2,
  parameter int BUSY_TIMEOUT   = 1000,
  localparam int CHAN_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  conv_clk_i,
  input  logic                  busy_i,
  input  logic [DATA_WIDTH-1:0] adc_data_i,
  output logic                  adc_cs_n_o,
  output logic                  adc_rd_n_o,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic [CHAN_W-1:0]     chan_o,
  output logic                  last_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o,
  output logic                  timeout_o,
  input  logic                  clear_i,
  output daq_state_e            dbg_state_o
);

  localparam int TMAX = max3(BUSY_TIMEOUT, RD_LOW_CYCLES, RD_HIGH_CYCLES);
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0]     TO_LAST   = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0]     RL_LAST   = TW'(RD_LOW_CYCLES - 1);
  localparam logic [TW-1:0]     RH_LAST   = TW'(RD_HIGH_CYCLES - 1);
  localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(NUM_CHANNELS - 1);

  daq_state_e state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CHAN_W-1:0] chan_q, chan_d;

  logic                  valid_d, last_d, cs_n_d, rd_n_d;
  logic [DATA_WIDTH-1:0] sample_d;
  logic [CHAN_W-1:0]     chan_out_d;
  logic                  overrun_d, timeout_d, timeout_set;

  logic busy_s;
  logic conv_q;
  logic start;

  // Busy comes straight from the ADC with no relation to clk_i.
  daq_sync2 #(.RESET_VAL(1'b0)) u_busy_sync (
    .clk   (clk_i),
    .reset (reset_i),
    .d     (busy_i),
    .q     (busy_s)
  );

  // The trigger controller is on clk_i, so a single register is enough
  // to see its falling edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) conv_q <= 1'b0;
    else         conv_q <= conv_clk_i;
  end

  assign start       = conv_q && !conv_clk_i;
  assign dbg_state_o = state_q;

  // Next-state, timer, channel and output-register values.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    chan_d      = chan_q;
    valid_d     = valid_o;
    sample_d    = sample_o;
    chan_out_d  = chan_o;
    last_d      = last_o;
    timeout_set = 1'b0;

    if (valid_o && ready_i) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && en_i) begin
          state_d = WAIT_BUSY_HI;
          timer_d = '0;
        end
      end
      WAIT_BUSY_HI: begin
        if (busy_s == HI) begin
          state_d = WAIT_BUSY_LO;
          timer_d = '0;
        end else if (timer_q == TO_LAST) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_BUSY_LO: begin
        if (busy_s == LO) begin
          state_d = RD_LOW;
          chan_d  = '0;
          timer_d = '0;
        end else if (timer_q == TO_LAST) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RD_LOW: begin
        // Data is taken on the last low cycle, while RD_n is still asserted.
        if (timer_q == RL_LAST) begin
          sample_d   = adc_data_i;
          chan_out_d = chan_q;
          last_d     = (chan_q == CHAN_LAST);
          valid_d    = 1'b1;
          state_d    = RD_HIGH;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RD_HIGH: begin
        if (timer_q == RH_LAST) begin
          state_d = OUT_WAIT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      OUT_WAIT: begin
        // Leave once the beat has gone, whether it went earlier or now.
        if (!valid_o || ready_i) begin
          timer_d = '0;
          if (last_o) begin
            state_d = IDLE;
          end else begin
            chan_d  = chan_q + CHAN_W'(1);
            state_d = RD_LOW;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Disable wins over everything: drop the frame and the pending beat.
    if (!en_i) begin
      state_d = IDLE;
      timer_d = '0;
      valid_d = 1'b0;
    end

    cs_n_d = !(state_d inside {RD_LOW, RD_HIGH, OUT_WAIT});
    rd_n_d = (state_d != RD_LOW);

    // Sticky flags: clear first so a same-cycle set event wins.
    overrun_d = (clear_i ? 1'b0 : overrun_o) | (start && (state_q != IDLE));
    timeout_d = (clear_i ? 1'b0 : timeout_o) | timeout_set;
  end

  // Sequencer state, shared timer and channel counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      chan_q  <= chan_d;
    end
  end

  // Registered bus strobes, stream outputs and sticky flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      adc_cs_n_o <= 1'b1;
      adc_rd_n_o <= 1'b1;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      sample_o   <= '0;
      chan_o     <= '0;
      overrun_o  <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      adc_cs_n_o <= cs_n_d;
      adc_rd_n_o <= rd_n_d;
      valid_o    <= valid_d;
      last_o     <= last_d;
      sample_o   <= sample_d;
      chan_o     <= chan_out_d;
      overrun_o  <= overrun_d;
      timeout_o  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_daq_adc_readout.sv
// Directed bench for daq_adc_readout with an ADC bus model and beat monitor.
module tb_daq_adc_readout;
  import daq_pkg::*;

  localparam int NCH    = 8;
  localparam int DW     = 16;
  localparam int CW     = 3;
  localparam int RL     = 3;
  localparam int RH     = 2;
  localparam int BTO    = 1000;
  localparam int BW     = 1 + CW + DW;

  logic          clk;
  logic          reset_i, en_i, conv_clk_i, busy_i, ready_i, clear_i;
  logic [DW-1:0] adc_data_i;
  logic          adc_cs_n_o, adc_rd_n_o, last_o, valid_o, overrun_o, timeout_o;
  logic [DW-1:0] sample_o;
  logic [CW-1:0] chan_o;
  daq_state_e    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];

  // ADC model and bus-timing monitor state.
  int   rd_cnt  = 0;
  logic rd_prev = 1'b1;
  int   lo_run  = 0;
  int   hi_run  = 0;
  int   lo_err  = 0;
  int   hi_min  = 999;
  int   cs_bad  = 0;

  daq_adc_readout #(
    .NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .RD_LOW_CYCLES(RL),
    .RD_HIGH_CYCLES(RH), .BUSY_TIMEOUT(BTO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .conv_clk_i(conv_clk_i),
    .busy_i(busy_i), .adc_data_i(adc_data_i), .adc_cs_n_o(adc_cs_n_o),
    .adc_rd_n_o(adc_rd_n_o), .sample_o(sample_o), .chan_o(chan_o),
    .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i),
    .overrun_o(overrun_o), .timeout_o(timeout_o), .clear_i(clear_i),
    .dbg_state_o(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model: word k of a frame reads as 16'h1000 + k, k = completed RD_n pulses.
  assign adc_data_i = 16'h1000 + 16'(rd_cnt);

  always @(negedge clk) begin
    if (adc_cs_n_o) rd_cnt <= 0;
    else if (!rd_prev && adc_rd_n_o) rd_cnt <= rd_cnt + 1;
  end

  // Beat monitor and RD_n low/high run-length tracking.
  always @(negedge clk) begin
    if (reset_i || !en_i) begin
      lo_run  <= 0;
      hi_run  <= 0;
      rd_prev <= adc_rd_n_o;
    end else begin
      if (valid_o && ready_i) got_q.push_back({last_o, chan_o, sample_o});
      if (valid_o && adc_cs_n_o) cs_bad <= cs_bad + 1;
      if (adc_cs_n_o) begin
        lo_run <= 0;
        hi_run <= 0;
      end else if (!adc_rd_n_o) begin
        lo_run <= lo_run + 1;
        if (rd_prev && hi_run > 0 && hi_run < hi_min) hi_min <= hi_run;
        hi_run <= 0;
      end else begin
        hi_run <= hi_run + 1;
        if (!rd_prev && lo_run > 0 && lo_run != RL) lo_err <= lo_err + 1;
        lo_run <= 0;
      end
      rd_prev <= adc_rd_n_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Conversion start: falling edge of conv_clk_i.
  task automatic do_start();
    conv_clk_i = 1'b1;
    tick(1);
    conv_clk_i = 1'b0;
    tick(1);
  endtask

  task automatic busy_pulse(input int n);
    tick(3);
    busy_i = 1'b1;
    tick(n);
    busy_i = 1'b0;
  endtask

  task automatic expect_beats(input int n);
    for (int c = 0; c < n; c++) begin
      logic [DW-1:0] s;
      logic          l;
      s = 16'h1000 + 16'(c);
      l = (c == NCH - 1);
      exp_q.push_back({l, CW'(c), s});
    end
  endtask

  task automatic check_beats(input string tag, input int budget);
    int n;
    logic [BW-1:0] e, g;
    n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : '1;
      chk({tag, "_beat"}, 32'(g), 32'(e));
    end
    tick(4);
    chk({tag, "_extra"}, 32'(got_q.size()), 32'd0);
  endtask

  task automatic wait_chan(input string tag, input int c, input int budget);
    int n;
    n = 0;
    while (!(valid_o && chan_o == CW'(c)) && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(valid_o && chan_o == CW'(c)), 32'd1);
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_cs_n"},    32'(adc_cs_n_o), 32'd1);
    chk({p, "_rd_n"},    32'(adc_rd_n_o), 32'd1);
    chk({p, "_valid"},   32'(valid_o),    32'd0);
    chk({p, "_last"},    32'(last_o),     32'd0);
    chk({p, "_sample"},  32'(sample_o),   32'd0);
    chk({p, "_chan"},    32'(chan_o),     32'd0);
    chk({p, "_overrun"}, 32'(overrun_o),  32'd0);
    chk({p, "_timeout"}, 32'(timeout_o),  32'd0);
    chk({p, "_state"},   32'(dbg_state),  32'(IDLE));
  endtask

  initial begin
    int n;
    int hold_bad;

    // Reset
    reset_i = 1'b1; en_i = 1'b1; conv_clk_i = 1'b0; busy_i = 1'b0;
    ready_i = 1'b1; clear_i = 1'b0;
    tick(3);
    chk_reset_vals("reset");
    reset_i = 1'b0;
    tick(2);

    // 1. Nominal frame
    expect_beats(NCH);
    do_start();
    chk("nom_wait_state", 32'(dbg_state), 32'(WAIT_BUSY_HI));
    chk("nom_cs_idle", 32'(adc_cs_n_o), 32'd1);
    busy_pulse(50);
    check_beats("nom", 500);
    chk("nom_state_end", 32'(dbg_state), 32'(IDLE));
    chk("nom_cs_end", 32'(adc_cs_n_o), 32'd1);
    chk("nom_last_clr", 32'(valid_o), 32'd0);
    chk("nom_rd_low_len", 32'(lo_err), 32'd0);
    // Gap is the RD_HIGH cycles plus the one OUT_WAIT pass-through cycle.
    chk("nom_rd_high_len", 32'(hi_min), 32'(RH + 1));

    // 2. Backpressure at channel 3
    expect_beats(NCH);
    do_start();
    busy_pulse(20);
    wait_chan("bp_reach_ch3", 3, 200);
    ready_i = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (valid_o !== 1'b1 || sample_o !== 16'h1003 || chan_o !== 3'd3 ||
          last_o !== 1'b0 || adc_rd_n_o !== 1'b1 || adc_cs_n_o !== 1'b0)
        hold_bad++;
    end
    chk("bp_hold", 32'(hold_bad), 32'd0);
    chk("bp_no_ch4", 32'(got_q.size()), 32'd3);
    ready_i = 1'b1;
    check_beats("bp", 500);

    // 3. Overrun at channel 2, with a same-cycle clear that must lose
    expect_beats(NCH);
    do_start();
    busy_pulse(10);
    wait_chan("ovr_reach_ch2", 2, 200);
    conv_clk_i = 1'b1;
    tick(1);
    conv_clk_i = 1'b0;
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("ovr_set_wins", 32'(overrun_o), 32'd1);
    check_beats("ovr", 500);
    tick(20);
    chk("ovr_no_second", 32'(dbg_state), 32'(IDLE));
    chk("ovr_no_timeout", 32'(timeout_o), 32'd0);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("ovr_clear", 32'(overrun_o), 32'd0);

    // 4. Timeout: busy never rises
    do_start();
    n = 0;
    while (!timeout_o && n < BTO + 100) begin
      tick(1);
      n++;
    end
    chk("to_flag", 32'(timeout_o), 32'd1);
    chk("to_latency", 32'(n >= BTO && n <= BTO + 3), 32'd1);
    chk("to_state", 32'(dbg_state), 32'(IDLE));
    chk("to_no_beats", 32'(got_q.size()), 32'd0);
    chk("to_cs", 32'(adc_cs_n_o), 32'd1);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("to_clear", 32'(timeout_o), 32'd0);

    // 5. Abort with en_i low while channel 5 is valid
    expect_beats(5);
    do_start();
    busy_pulse(10);
    wait_chan("ab_reach_ch5", 5, 200);
    en_i = 1'b0;
    ready_i = 1'b0;
    tick(1);
    chk("ab_valid", 32'(valid_o), 32'd0);
    chk("ab_cs_n", 32'(adc_cs_n_o), 32'd1);
    chk("ab_rd_n", 32'(adc_rd_n_o), 32'd1);
    chk("ab_state", 32'(dbg_state), 32'(IDLE));
    check_beats("ab_part", 10);
    en_i = 1'b1;
    ready_i = 1'b1;
    tick(2);
    expect_beats(NCH);
    do_start();
    busy_pulse(10);
    check_beats("ab_new", 500);

    // 6. Reset mid-frame, then a clean frame with RD_n timing
    do_start();
    busy_pulse(10);
    wait_chan("rst_reach_ch2", 2, 200);
    reset_i = 1'b1;
    tick(1);
    chk_reset_vals("rst_mid");
    reset_i = 1'b0;
    got_q.delete();
    hi_min = 999;
    tick(2);
    expect_beats(NCH);
    do_start();
    busy_pulse(10);
    check_beats("rst_new", 500);
    chk("rst_rd_low_len", 32'(lo_err), 32'd0);
    chk("rst_rd_high_len", 32'(hi_min), 32'(RH + 1));
    chk("cs_during_valid", 32'(cs_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
